mask_gen_pipe: RTL
==================

Name: mask_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational bit-range mask generator. It accepts per-lane low/high bit bounds plus a mode, and produces a LANES×LANE_W-bit mask and its population count. The block sits between the decode stage and the logic-immediate datapath. It uses a valid/ready handshake with full backpressure and has a fixed 2-cycle latency.

Parameters:
LANES, 2, number of independent mask lanes (≥1)
LANE_W, 32, bits per lane; power of two, ≥2
IDX_W, $clog2(LANE_W), bound index width (derived localparam, not overridable)
CNT_W, $clog2(LANES*LANE_W+1), popcount width (derived localparam)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_l  input  1  synchronous reset, active-low
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_lo  input  LANES*IDX_W  per-lane low bound; lane k occupies [k*IDX_W +: IDX_W]
in_hi  input  LANES*IDX_W  per-lane high bound, same packing
in_mode  input  2  00 RANGE, 01 WRAP, 10 INVERT, 11 ONEHOT
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_mask  output  LANES*LANE_W  mask; lane k occupies [k*LANE_W +: LANE_W]
out_count  output  CNT_W  number of set bits in out_mask

Behaviour:
- Reset and clocking are as stated above: one clock, reset_l synchronous and active-low.
- Reset (reset_l=0 at a rising edge):
  - Both pipeline stage valid flags clear.
  - out_valid=0, out_mask=0, out_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight requests. No partial output appears.
- Per-lane bit i of lane k, with lo and hi compared unsigned, for each mode:
  - RANGE: set when lo ≤ i ≤ hi. When lo > hi the lane is all zeros.
  - WRAP: same as RANGE when lo ≤ hi. When lo > hi, set when i ≥ lo or i ≤ hi (wrap-around range).
  - INVERT: bitwise NOT of the RANGE result.
  - ONEHOT: set only when i == lo; hi is ignored.
- Pipeline:
  - Stage 1 registers in_mode and the per-lane masks. Mask computation uses full-width index compares; index truncation is not allowed.
  - Stage 2 registers out_mask and out_count. out_count is the popcount of the stage-1 mask.
  - A request accepted in cycle N (in_valid & in_ready) appears on out_valid in cycle N+2 when there is no stall.
- Handshake:
  - Stage 2 advances when it is empty or out_ready=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - in_ready = stage-1 advance condition. It is combinational from out_ready and the stage valid flags only, never from in_valid.
  - Throughput is one request per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, out_mask and out_count hold stable.
  - Back-to-back requests are accepted with no bubbles.
- Simultaneous events:
  - Accepting a new input in the same cycle that stage 2 drains is legal. No request is lost or duplicated.
  - in_valid=0 inserts a bubble. The stage valid flag clears and register contents are don't-care, but out_mask and out_count must be zero-gated when out_valid=0.
- Boundaries:
  - lo=hi gives a single set bit in RANGE and WRAP.
  - lo=0, hi=LANE_W-1 gives all ones.
  - ONEHOT with lo=LANE_W-1 sets the MSB of the lane.
  - Popcount saturation is impossible by construction of CNT_W.

Test Plan:
- Reset then defaults: reset_l low for 3 cycles → out_valid=0, out_mask=0, out_count=0, in_ready=1 on the first cycle after release.
- RANGE with defaults: lane0 lo=4 hi=7, lane1 lo=0 hi=31, mode=00 → out_mask=64'hFFFF_FFFF_0000_00F0, out_count=36, exactly 2 cycles after acceptance.
- WRAP vs RANGE: lane0 lo=30 hi=1, lane1 lo=5 hi=5; mode=01 → lane0=32'hC000_0003, lane1=32'h0000_0020, count=5. Same bounds with mode=00 → lane0=0, lane1=32'h0000_0020, count=1.
- INVERT and ONEHOT: lane0 lo=0 hi=15, lane1 lo=31 hi=0; mode=10 → 64'hFFFF_FFFF_FFFF_0000, count=48. Mode=11 → 64'h8000_0000_0000_0001, count=2.
- Backpressure:
  - Stimulus: stream 5 back-to-back requests; hold out_ready=0 for cycles 3–6.
  - in_ready drops once both stages are full.
  - Held output remains stable.
  - All 5 results emerge in order, with no loss or duplication.
  - Throughput returns to 1 per cycle once out_ready=1.
- Reset mid-stream: 2 requests in flight, reset_l=0 for 1 cycle → neither result ever appears. The next accepted request emerges after 2 cycles with the correct value.

Source files
------------

// File: rtl/mask_gen_pipe.sv
// mask_gen_pipe: pipelined per-lane bit-range mask generator with popcount.
//
// Each lane produces a LANE_W-bit mask from a low/high bit bound and a shared
// mode (RANGE, WRAP, INVERT, ONEHOT). The concatenated mask and its population
// count come out two cycles after acceptance, behind a valid/ready handshake
// with full backpressure.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset_l    synchronous reset, active-low
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   in_lo      per-lane low bound, lane k at [k*IDX_W +: IDX_W]
//   in_hi      per-lane high bound, same packing
//   in_mode    00 RANGE, 01 WRAP, 10 INVERT, 11 ONEHOT
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_mask   mask, lane k at [k*LANE_W +: LANE_W]; zero while out_valid=0
//   out_count  number of set bits in out_mask; zero while out_valid=0
module mask_gen_pipe #(
  parameter int LANES  = 2,
  parameter int LANE_W = 32,
  localparam int IDX_W = $clog2(LANE_W),
  localparam int CNT_W = $clog2(LANES*LANE_W+1)
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*IDX_W-1:0]  in_lo,
  input  logic [LANES*IDX_W-1:0]  in_hi,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_mask,
  output logic [CNT_W-1:0]        out_count
);

  typedef enum logic [1:0] {
    MODE_RANGE  = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_INVERT = 2'b10,
    MODE_ONEHOT = 2'b11
  } mode_e;

  localparam int MASK_W = LANES*LANE_W;

  mode_e              mode_in;
  logic [IDX_W-1:0]   lane_lo;
  logic [IDX_W-1:0]   lane_hi;
  logic               in_rng;
  logic [MASK_W-1:0]  mask_d;

  logic               s1_valid;
  mode_e              s1_mode;
  logic [MASK_W-1:0]  s1_mask;
  logic [MASK_W-1:0]  s1_eff;
  logic [CNT_W-1:0]   s1_cnt;

  logic               s2_adv;
  logic               s1_adv;

  assign mode_in = mode_e'(in_mode);

  // Handshake: a stage moves when it is empty or its successor moves.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Per-bit mask from full-width unsigned compares of the bit index against
  // the zero-extended bounds. INVERT stores the plain range here; the
  // inversion is applied on the stage-1 output so mode stays meaningful there.
  // NOTE: every variable assigned in this block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mask_d  = '0;
    lane_lo = '0;
    lane_hi = '0;
    in_rng  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_lo = in_lo[k*IDX_W +: IDX_W];
      lane_hi = in_hi[k*IDX_W +: IDX_W];
      for (int i = 0; i < LANE_W; i++) begin
        in_rng = (i >= int'(lane_lo)) && (i <= int'(lane_hi));
        case (mode_in)
          MODE_RANGE, MODE_INVERT: mask_d[k*LANE_W + i] = in_rng;
          MODE_WRAP: begin
            if (lane_lo <= lane_hi)
              mask_d[k*LANE_W + i] = in_rng;
            else
              mask_d[k*LANE_W + i] = (i >= int'(lane_lo)) || (i <= int'(lane_hi));
          end
          MODE_ONEHOT: mask_d[k*LANE_W + i] = (i == int'(lane_lo));
          default:     mask_d[k*LANE_W + i] = 1'b0;
        endcase
      end
    end
  end

  // Final stage-1 mask and its population count.
  always_comb begin
    s1_eff = (s1_mode == MODE_INVERT) ? ~s1_mask : s1_mask;
    s1_cnt = '0;
    for (int i = 0; i < MASK_W; i++) begin
      s1_cnt = s1_cnt + CNT_W'(s1_eff[i]);
    end
  end

  // Control and output registers. Output data is loaded with zero whenever a
  // bubble enters stage 2, so out_mask/out_count read zero while invalid.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_mask  <= s1_valid ? s1_eff : '0;
        out_count <= s1_valid ? s1_cnt : '0;
      end
    end
  end

  // Stage-1 payload.
  // NOTE: payload registers carry no reset; their contents are ignored while
  // s1_valid is low, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_mode <= mode_in;
      s1_mask <= mask_d;
    end
  end

endmodule
